// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
// UART receive deserializer. Oversamples an asynchronous serial line with a
// free-running clk, locates each frame by its start-bit falling edge, samples
// every bit at its middle and presents the received word with a one-cycle
// valid pulse. A low stop bit reports a frame error and parks the receiver in
// BREAK until the line returns high.
//
// Optional feature (macro UART_RX_PARITY_EN): one even-parity bit follows the
// data bits; a mismatch pulses parity_err_o instead of valid_o. With the macro
// undefined the frame is start + DATA_BITS + stop and parity_err_o is absent.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (>= 4)
//   DATA_BITS     data bits per frame (5..8)
// Ports
//   clk           clock, rising edge
//   arstn         asynchronous active-low reset
//   rx            serial line, asynchronous, idle high
//   data_o        last correctly received word, LSB = first bit on the line
//   valid_o       one-cycle pulse when data_o updates
//   frame_err_o   one-cycle pulse when the stop bit is sampled low
//   parity_err_o  one-cycle pulse on parity mismatch (UART_RX_PARITY_EN only)
// -----------------------------------------------------------------------------
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err_o
`endif
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  // First sample lands mid start bit; every later one is a full period on.
  localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;

`ifdef UART_RX_PARITY_EN
  // Even parity: the expected parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction
`endif

  state_e                state_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [DATA_BITS-1:0]  data_q;
  logic                  valid_q;
  logic                  ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                  perr_q;
  logic                  par_bad_q;
`endif

  logic rx_meta_q;
  logic rxs_q;
  logic rxs_prev_q;
  logic fall_s;
  logic expire_s;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // The history flop runs in every state, so an edge arriving right as the
  // FSM re-enters IDLE is still seen as a 1->0 transition.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign fall_s   = rxs_prev_q & ~rxs_q;
  assign expire_s = (baud_q == '0);

  // Frame FSM with baud/bit counters and registered result pulses.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      if (!expire_s) begin
        baud_q <= baud_q - BAUD_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (fall_s) begin
            state_q <= START;
            baud_q  <= HALF_LOAD;
          end
        end
        START: begin
          if (expire_s) begin
            if (rxs_q) begin
              // Glitch shorter than half a bit: drop it silently.
              state_q <= IDLE;
              baud_q  <= '0;
            end else begin
              state_q <= DATA;
              bit_q   <= '0;
              baud_q  <= FULL_LOAD;
            end
          end
        end
        DATA: begin
          if (expire_s) begin
            // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
            shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
            baud_q  <= FULL_LOAD;
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (expire_s) begin
            // Result is held until the stop bit so a frame error can win.
            par_bad_q <= rxs_q ^ even_parity(shift_q);
            state_q   <= STOP;
            baud_q    <= FULL_LOAD;
          end
        end
`endif
        STOP: begin
          if (expire_s) begin
            baud_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                perr_q <= 1'b1;
              end else begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end
`else
              data_q  <= shift_q;
              valid_q <= 1'b1;
`endif
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end
        end
        BREAK: begin
          // Only a return to idle-high re-arms the receiver.
          if (rxs_q) begin
            state_q <= IDLE;
            baud_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule
